// File: rtl/sdram_port_arb.sv
// sdram_port_arb
//   Multi-channel burst arbiter in front of a single SDRAM controller.
//   Each channel owns a write region and a read region with its own
//   running address. When a channel's write FIFO holds a full burst, or
//   its read FIFO has room for one, the arbiter requests a burst from the
//   controller and steers the controller's acknowledge to that channel's
//   FIFO strobe. Writes always beat reads.
//
//   Optional feature: define SDRAM_ARB_RR_EN for round-robin arbitration
//   (separate write/read pointers). Without it, the lowest channel wins.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   init_end                         SDRAM initialisation complete
//   wr_burst_len / rd_burst_len      burst length shared by all channels
//   wr_b_addr/wr_e_addr/rd_b_addr/rd_e_addr
//                                    per-channel region begin/end, packed
//   wr_fifo_num / rd_fifo_num        per-channel FIFO fill levels, packed
//   rd_valid                         per-channel read enable
//   wr_rst / rd_rst                  per-channel address reload to begin
//   sdram_wr_ack / sdram_rd_ack      controller burst acknowledges
//   sdram_wr_req / sdram_rd_req      burst requests
//   sdram_wr_addr / sdram_rd_addr    burst start address of granted channel
//   grant_ch                         currently granted channel
//   wr_fifo_rd_en / rd_fifo_wr_en    per-channel FIFO strobes
module sdram_port_arb #(
  parameter int CH_NUM = 2,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int CNT_W  = 10,
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_end,
  input  logic [LEN_W-1:0]         wr_burst_len,
  input  logic [LEN_W-1:0]         rd_burst_len,
  input  logic [CH_NUM*ADDR_W-1:0] wr_b_addr,
  input  logic [CH_NUM*ADDR_W-1:0] wr_e_addr,
  input  logic [CH_NUM*ADDR_W-1:0] rd_b_addr,
  input  logic [CH_NUM*ADDR_W-1:0] rd_e_addr,
  input  logic [CH_NUM*CNT_W-1:0]  wr_fifo_num,
  input  logic [CH_NUM*CNT_W-1:0]  rd_fifo_num,
  input  logic [CH_NUM-1:0]        rd_valid,
  input  logic [CH_NUM-1:0]        wr_rst,
  input  logic [CH_NUM-1:0]        rd_rst,
  input  logic                     sdram_wr_ack,
  input  logic                     sdram_rd_ack,
  output logic                     sdram_wr_req,
  output logic                     sdram_rd_req,
  output logic [ADDR_W-1:0]        sdram_wr_addr,
  output logic [ADDR_W-1:0]        sdram_rd_addr,
  output logic [CH_W-1:0]          grant_ch,
  output logic [CH_NUM-1:0]        wr_fifo_rd_en,
  output logic [CH_NUM-1:0]        rd_fifo_wr_en
);

  localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

  state_t state, state_nxt;
  logic wr_ack_q, rd_ack_q;
  logic [CH_NUM-1:0] wr_elig, rd_elig;
  logic wr_any, rd_any;
  logic [CH_W-1:0] wr_win, rd_win;
  logic grant_wr, grant_rd, wr_done, rd_done, wr_phase, rd_phase;
  logic [ADDR_W-1:0] wr_addr [CH_NUM];
  logic [ADDR_W-1:0] rd_addr [CH_NUM];

  // Next address computed one bit wider so a region ending at the top of
  // the address space still wraps instead of overflowing to zero.
  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] addr,
                                                input logic [LEN_W-1:0]  len,
                                                input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] e);
    logic [ADDR_W:0] nxt;
    nxt = {1'b0, addr} + (ADDR_W+1)'(len);
    return (nxt < {1'b0, e}) ? nxt[ADDR_W-1:0] : b;
  endfunction

`ifdef SDRAM_ARB_RR_EN
  logic [CH_W-1:0] wr_ptr, rd_ptr;

  // Search begins just after the last winner so every channel gets a turn.
  function automatic logic [CH_W-1:0] pick(input logic [CH_NUM-1:0] elig,
                                           input logic [CH_W-1:0]   ptr);
    logic [CH_W-1:0] win;
    logic found;
    int idx;
    win = '0;
    found = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = (int'(ptr) + 1 + k) % CH_NUM;
      if (!found && elig[idx]) begin
        win = CH_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign wr_win = pick(wr_elig, wr_ptr);
  assign rd_win = pick(rd_elig, rd_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (grant_wr) begin
      wr_ptr <= wr_win;
    end else if (grant_rd) begin
      rd_ptr <= rd_win;
    end
  end
`else
  // Descending scan so the lowest eligible index is written last and wins.
  function automatic logic [CH_W-1:0] pick(input logic [CH_NUM-1:0] elig);
    logic [CH_W-1:0] win;
    win = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (elig[k]) win = CH_W'(k);
    end
    return win;
  endfunction

  assign wr_win = pick(wr_elig);
  assign rd_win = pick(rd_elig);
`endif

  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      wr_elig[i] = CMP_W'(wr_fifo_num[i*CNT_W +: CNT_W]) >= CMP_W'(wr_burst_len);
      rd_elig[i] = rd_valid[i] &&
                   (CMP_W'(rd_fifo_num[i*CNT_W +: CNT_W]) < CMP_W'(rd_burst_len));
    end
  end

  assign wr_any   = |wr_elig;
  assign rd_any   = |rd_elig;
  assign grant_wr = (state == IDLE) && init_end && wr_any;
  assign grant_rd = (state == IDLE) && init_end && !wr_any && rd_any;
  // A burst ends on the cycle after the controller drops its acknowledge.
  assign wr_done  = (state == WR_BUSY) && wr_ack_q && !sdram_wr_ack;
  assign rd_done  = (state == RD_BUSY) && rd_ack_q && !sdram_rd_ack;
  assign wr_phase = (state == WR_REQ) || (state == WR_BUSY);
  assign rd_phase = (state == RD_REQ) || (state == RD_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ack_q <= sdram_wr_ack;
      rd_ack_q <= sdram_rd_ack;
    end
  end

  // init_end is only consulted in IDLE, so a burst already under way is
  // carried through to completion even if initialisation status drops.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_wr) state_nxt = WR_REQ;
               else if (grant_rd) state_nxt = RD_REQ;
      WR_REQ:  if (sdram_wr_ack) state_nxt = WR_BUSY;
      WR_BUSY: if (wr_done) state_nxt = IDLE;
      RD_REQ:  if (sdram_rd_ack) state_nxt = RD_BUSY;
      RD_BUSY: if (rd_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) grant_ch <= '0;
    else if (grant_wr) grant_ch <= wr_win;
    else if (grant_rd) grant_ch <= rd_win;
  end

  // Reload requests take precedence over the end-of-burst advance.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (rst) begin
        wr_addr[i] <= '0;
        rd_addr[i] <= '0;
      end else begin
        if (wr_rst[i])
          wr_addr[i] <= wr_b_addr[i*ADDR_W +: ADDR_W];
        else if (wr_done && (grant_ch == CH_W'(i)))
          wr_addr[i] <= advance(wr_addr[i], wr_burst_len,
                                wr_b_addr[i*ADDR_W +: ADDR_W],
                                wr_e_addr[i*ADDR_W +: ADDR_W]);
        if (rd_rst[i])
          rd_addr[i] <= rd_b_addr[i*ADDR_W +: ADDR_W];
        else if (rd_done && (grant_ch == CH_W'(i)))
          rd_addr[i] <= advance(rd_addr[i], rd_burst_len,
                                rd_b_addr[i*ADDR_W +: ADDR_W],
                                rd_e_addr[i*ADDR_W +: ADDR_W]);
      end
    end
  end

  // Requests and strobes are forced low while reset is held, since the
  // state register only clears on the reset edge.
  assign sdram_wr_req  = !rst && (state == WR_REQ);
  assign sdram_rd_req  = !rst && (state == RD_REQ);
  assign sdram_wr_addr = wr_addr[grant_ch];
  assign sdram_rd_addr = rd_addr[grant_ch];

  always_comb begin
    wr_fifo_rd_en = '0;
    rd_fifo_wr_en = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      wr_fifo_rd_en[i] = !rst && sdram_wr_ack && wr_phase && (grant_ch == CH_W'(i));
      rd_fifo_wr_en[i] = !rst && sdram_rd_ack && rd_phase && (grant_ch == CH_W'(i));
    end
  end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameters SHALL be: CH_NUM, default 2, number of channels (1..8); ADDR_W, default 24, SDRAM word address width; LEN_W, default 10, burst length width; CNT_W, default 10, FIFO fill-count width; CH_W = max(1, clog2(CH_NUM)).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- init_end  in  1  SDRAM initialisation complete
- wr_burst_len / rd_burst_len  in  LEN_W  burst length, shared by all channels
- wr_b_addr / wr_e_addr / rd_b_addr / rd_e_addr  in  CH_NUM*ADDR_W  per-channel region begin/end (channel i at bits [i*ADDR_W +: ADDR_W])
- wr_fifo_num / rd_fifo_num  in  CH_NUM*CNT_W  per-channel FIFO fill levels
- rd_valid / wr_rst / rd_rst  in  CH_NUM  per-channel read enable and address reloads
- sdram_wr_ack / sdram_rd_ack  in  1  controller burst acknowledges
- sdram_wr_req / sdram_rd_req  out  1  burst requests
- sdram_wr_addr / sdram_rd_addr  out  ADDR_W  burst start address
- grant_ch  out  CH_W  currently granted channel
- wr_fifo_rd_en / rd_fifo_wr_en  out  CH_NUM  per-channel FIFO strobes

Function
REQ-003 The block SHALL keep one write-address and one read-address register per channel.
REQ-004 The FSM SHALL have the states IDLE, WR_REQ, WR_BUSY, RD_REQ and RD_BUSY.
REQ-005 In IDLE with init_end=1, channel i SHALL be write-eligible when wr_fifo_num[i] >= wr_burst_len, and read-eligible when rd_valid[i]=1 and rd_fifo_num[i] < rd_burst_len.
REQ-006 IDLE SHALL go to WR_REQ if any channel is write-eligible, else to RD_REQ if any is read-eligible; write beats read; grant_ch SHALL latch the winner on the same edge.
REQ-007 With init_end=0, IDLE SHALL stay put and issue no request.
REQ-008 In WR_REQ/RD_REQ the matching req SHALL be 1; on the first cycle with ack=1 the FSM SHALL move to *_BUSY and req SHALL be 0 from the next cycle.
REQ-009 In *_BUSY the FSM SHALL return to IDLE on the cycle after ack falls (registered ack high, current ack low); that same edge SHALL advance the granted channel's address.
REQ-010 Address advance: next = addr + len at ADDR_W+1 bits; if next < e_addr then addr <= next, else addr <= b_addr (wrap).
REQ-011 sdram_wr_addr/sdram_rd_addr SHALL equal the granted channel's write/read address register, muxed combinationally from registers.
REQ-012 wr_fifo_rd_en[i] SHALL = sdram_wr_ack & (state is WR_REQ or WR_BUSY) & (grant_ch==i); rd_fifo_wr_en[i] SHALL be the same with rd terms; all other bits SHALL be 0.
REQ-013 wr_rst[i]/rd_rst[i] SHALL load b_addr of channel i on the next edge in any state, and SHALL win over a simultaneous advance; an in-flight burst SHALL still complete.
REQ-014 init_end falling mid-burst SHALL NOT abort the burst.
REQ-015 Minimum IDLE dwell SHALL be one cycle between bursts.

Reset
REQ-016 While rst=1 the block SHALL hold state=IDLE, both reqs=0, all address registers=0, grant_ch=0, round-robin pointers=0, all strobes=0.
REQ-017 rst asserted mid-burst SHALL abandon the burst immediately, with no address advance.

Configuration
REQ-018 Macro SDRAM_ARB_RR_EN defined: independent write and read round-robin pointers SHALL be kept; the search SHALL start at pointer+1 (mod CH_NUM); the pointer SHALL be set to the granted channel on each grant.
REQ-019 Macro SDRAM_ARB_RR_EN undefined: fixed priority SHALL apply, lowest channel index wins, and no pointer registers SHALL exist.

Verification
REQ-020 CH_NUM=2, len=4, ch0 wr_fifo_num=4, init_end=1 -> sdram_wr_req=1, addr=b_addr0; ack 4 cycles -> wr_fifo_rd_en=01 for 4 cycles, addr0 += 4.
REQ-021 b=0, e=8, len=4, two write bursts -> addresses 0, 4, then reload to 0.
REQ-022 Both channels write-eligible continuously, RR_EN defined -> grants 1,0,1,0; RR_EN undefined -> grants 0,0,0.
REQ-023 ch1 write-eligible and ch0 read-eligible together -> write granted first; read granted on the following IDLE.
REQ-024 wr_rst[0] on the same cycle as ch0 ack falls -> addr0 = b_addr0, no advance.
REQ-025 rst pulsed during WR_BUSY -> next cycle state IDLE, reqs 0, all addresses 0.
